// File: rtl/wiper_pkg.sv
// Shared wiper types: speed encoding (also emitted by the speed-selector FSM)
// and the sweep sequencer state set.
package wiper_pkg;
  typedef enum logic [1:0] {MODE_OFF = 2'b00, MODE_SLOW = 2'b01, MODE_FAST = 2'b10} wiper_mode_t;
  typedef enum logic [1:0] {PARKED, SWEEP_OUT, SWEEP_BACK, DWELL} sweep_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/wiper_step_timer.sv
// Arm step prescaler: counts while enabled and emits a one-cycle step_tick
// when the count reaches the selected period minus one.
module wiper_step_timer #(
  parameter int SLOW_DIV = 4,
  parameter int FAST_DIV = 2,
  parameter int CNT_W    = 4
) (
  input  logic clk_2,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  input  logic fast_i,
  output logic step_tick_o
);
  logic [CNT_W-1:0] tmr_q, tmr_d, last;

  assign last        = fast_i ? CNT_W'(FAST_DIV - 1) : CNT_W'(SLOW_DIV - 1);
  assign step_tick_o = en_i && (tmr_q == last);

  always_comb begin
    tmr_d = tmr_q;
    if (clr_i || step_tick_o) tmr_d = '0;
    else if (en_i)            tmr_d = tmr_q + CNT_W'(1);
  end

  always_ff @(posedge clk_2) begin
    if (reset) tmr_q <= '0;
    else       tmr_q <= tmr_d;
  end
endmodule

// File: rtl/wiper_motor_sequencer.sv
// Wiper arm sequencer: full out/back sweeps at the latched speed; speed and
// stop requests are only honoured with the arm at park.
module wiper_motor_sequencer
  import wiper_pkg::*;
#(
  parameter int  POS_MAX      = 7,
  parameter int  SLOW_DIV     = 4,
  parameter int  FAST_DIV     = 2,
  parameter int  DWELL_CYCLES = 8,
  localparam int POS_W        = $clog2(POS_MAX + 1)
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic [1:0]       mode_req_i,
  output logic [1:0]       mode_active_o,
  output logic [POS_W-1:0] arm_pos_o,
  output logic             motor_on_o,
  output logic             motor_dir_o,
  output logic             parked_o,
  output logic             sweep_done_o,
  output logic [7:0]       sweep_cnt_o
);
  localparam int CNT_W = $clog2(max3(SLOW_DIV, FAST_DIV, DWELL_CYCLES) + 1);
  localparam logic [POS_W-1:0] POS_TOP  = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(POS_MAX - 1);
  localparam logic [CNT_W-1:0] DW_LAST  = CNT_W'(DWELL_CYCLES - 1);

  sweep_state_t     state_q, state_d;
  wiper_mode_t      mode_q, mode_d;
  logic [POS_W-1:0] pos_q;
  logic [CNT_W-1:0] dwell_q;
  logic [7:0]       cnt_q;
  logic             done_q;
  logic             step_tick, tmr_clr, sweep_end, req_slow, req_fast;

  assign req_slow  = (mode_req_i == MODE_SLOW);
  assign req_fast  = (mode_req_i == MODE_FAST);
  assign sweep_end = (state_q == SWEEP_BACK) && step_tick && (pos_q == POS_W'(1));
  assign tmr_clr   = (state_d == SWEEP_OUT) && (state_q != SWEEP_OUT);

  wiper_step_timer #(
    .SLOW_DIV(SLOW_DIV), .FAST_DIV(FAST_DIV), .CNT_W(CNT_W)
  ) u_step_timer (
    .clk_2      (clk_2),
    .reset      (reset),
    .en_i       ((state_q == SWEEP_OUT) || (state_q == SWEEP_BACK)),
    .clr_i      (tmr_clr),
    .fast_i     (mode_q == MODE_FAST),
    .step_tick_o(step_tick)
  );

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q <= PARKED;
      mode_q  <= MODE_OFF;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  // Reserved 2'b11 falls through every branch as "off".
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    case (state_q)
      PARKED: begin
        if (req_fast)      begin state_d = SWEEP_OUT; mode_d = MODE_FAST; end
        else if (req_slow) begin state_d = SWEEP_OUT; mode_d = MODE_SLOW; end
        else               mode_d = MODE_OFF;
      end
      SWEEP_OUT: if (step_tick && pos_q == POS_LAST) state_d = SWEEP_BACK;
      SWEEP_BACK: begin
        if (sweep_end) begin
          if (req_fast)      begin state_d = SWEEP_OUT; mode_d = MODE_FAST; end
          else if (req_slow) begin state_d = DWELL;     mode_d = MODE_SLOW; end
          else               begin state_d = PARKED;    mode_d = MODE_OFF;  end
        end
      end
      DWELL: begin
        if (req_fast)               begin state_d = SWEEP_OUT; mode_d = MODE_FAST; end
        else if (!req_slow)         begin state_d = PARKED;    mode_d = MODE_OFF;  end
        else if (dwell_q == DW_LAST) state_d = SWEEP_OUT;
      end
      default: state_d = PARKED;
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      pos_q   <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= sweep_end;
      if (sweep_end) cnt_q <= cnt_q + 8'd1;
      if (step_tick && state_q == SWEEP_OUT && pos_q != POS_TOP)
        pos_q <= pos_q + POS_W'(1);
      else if (step_tick && state_q == SWEEP_BACK && pos_q != '0)
        pos_q <= pos_q - POS_W'(1);
      dwell_q <= (state_q == DWELL && state_d == DWELL) ? dwell_q + CNT_W'(1) : '0;
    end
  end

  always_comb begin
    motor_on_o  = (state_q == SWEEP_OUT) || (state_q == SWEEP_BACK);
    motor_dir_o = (state_q == SWEEP_OUT);
    parked_o    = (state_q == PARKED) || (state_q == DWELL);
  end

  assign mode_active_o = mode_q;
  assign arm_pos_o     = pos_q;
  assign sweep_done_o  = done_q;
  assign sweep_cnt_o   = cnt_q;
endmodule

// File: tb/tb_wiper_motor_sequencer.sv
// Randomised and directed bench; the reference tracks elapsed time within a
// sweep and derives arm position arithmetically from it.
module tb_wiper_motor_sequencer;
  localparam int POS_MAX = 7, SLOW_DIV = 4, FAST_DIV = 2, DWELL = 8;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode_req = 2'b00;
  logic [1:0] mode_active;
  logic [2:0] arm_pos;
  logic       motor_on, motor_dir, parked, sweep_done;
  logic [7:0] sweep_cnt;
  logic [16:0] dut_v;

  int errors = 0, checks = 0, cyc_n = 0;

  // reference: phase 0 parked, 1 sweeping, 2 dwelling
  int         m_ph = 0, m_t = 0, m_d = 0;
  logic [1:0] m_mode = 2'b00;
  logic [7:0] m_cnt = 8'd0;
  logic       m_done = 1'b0;

  wiper_motor_sequencer dut (
    .clk_2(clk_2), .reset(reset), .mode_req_i(mode_req),
    .mode_active_o(mode_active), .arm_pos_o(arm_pos), .motor_on_o(motor_on),
    .motor_dir_o(motor_dir), .parked_o(parked), .sweep_done_o(sweep_done),
    .sweep_cnt_o(sweep_cnt)
  );

  always #5 clk_2 = ~clk_2;

  assign dut_v = {mode_active, arm_pos, motor_on, motor_dir, parked, sweep_done, sweep_cnt};

  function automatic int per(input logic [1:0] m);
    return (m == 2'b10) ? FAST_DIV : SLOW_DIV;
  endfunction

  function automatic logic [16:0] expv();
    int p, pos;
    logic on, dir;
    p   = per(m_mode);
    on  = (m_ph == 1);
    dir = on && (m_t < POS_MAX * p);
    if (!on) pos = 0;
    else if (m_t < POS_MAX * p) pos = m_t / p;
    else pos = 2 * POS_MAX - m_t / p;
    return {m_mode, 3'(pos), on, dir, !on, m_done, m_cnt};
  endfunction

  // advance one clock; inputs are sampled before the edge and the reference
  // is updated alongside the DUT, returning at the falling edge
  task automatic cyc();
    logic [1:0] rq;
    logic rs;
    rq = mode_req;
    rs = reset;
    @(posedge clk_2);
    m_done = 1'b0;
    if (rs) begin
      m_ph = 0; m_t = 0; m_d = 0; m_mode = 2'b00; m_cnt = 8'd0;
    end else begin
      case (m_ph)
        0: if (rq == 2'b01 || rq == 2'b10) begin m_ph = 1; m_t = 0; m_mode = rq; end
           else m_mode = 2'b00;
        1: begin
          m_t++;
          if (m_t == 2 * POS_MAX * per(m_mode)) begin
            m_done = 1'b1;
            m_cnt++;
            if (rq == 2'b10)      begin m_t = 0; m_mode = 2'b10; end
            else if (rq == 2'b01) begin m_ph = 2; m_d = 0; m_mode = 2'b01; end
            else                  begin m_ph = 0; m_mode = 2'b00; end
          end
        end
        default: begin
          if (rq == 2'b10)       begin m_ph = 1; m_t = 0; m_mode = 2'b10; end
          else if (rq != 2'b01)  begin m_ph = 0; m_mode = 2'b00; end
          else if (m_d == DWELL - 1) begin m_ph = 1; m_t = 0; end
          else m_d++;
        end
      endcase
    end
    @(negedge clk_2);
    cyc_n++;
  endtask

  task automatic go_park();
    mode_req = 2'b00;
    for (int i = 0; i < 200 && m_ph != 0; i++) cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1; mode_req = 2'b00;
    cyc(); cyc();
    checks++;
    if (dut_v !== 17'b00_000_0_0_1_0_00000000) begin
      errors++; $display("FAIL reset_state got=%h exp=%h", dut_v, 17'b00_000_0_0_1_0_00000000);
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      checks++;
      if (dut_v !== expv()) begin errors++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc_n, dut_v, expv()); end
    end
    checks++;
    if (!(parked === 1'b1 && motor_on === 1'b0 && arm_pos === 3'd0 && sweep_cnt === 8'd0)) begin
      errors++; $display("FAIL reset_idle_const got=%h", dut_v);
    end
  endtask

  task automatic test_fast();
    int dc[$];
    mode_req = 2'b10;
    for (int i = 1; i <= 85; i++) begin
      cyc();
      checks++;
      if (dut_v !== expv()) begin errors++; $display("FAIL fast cyc=%0d got=%h exp=%h", cyc_n, dut_v, expv()); end
      if (i == 15) begin
        checks++;
        if (arm_pos !== 3'd7) begin errors++; $display("FAIL fast_top got=%0d exp=7", arm_pos); end
      end
      if (sweep_done) dc.push_back(i);
    end
    checks++;
    if (dc.size() != 3 || dc[0] != 29 || dc[1] != 57 || dc[2] != 85 || sweep_cnt !== 8'd3) begin
      errors++; $display("FAIL fast_period pulses=%0d first=%0d cnt=%0d exp 3/29/3", dc.size(), (dc.size() > 0) ? dc[0] : -1, sweep_cnt);
    end
  endtask

  task automatic test_slow();
    int dc[$];
    int dw = 0;
    go_park();
    mode_req = 2'b01;
    for (int i = 1; i <= 185; i++) begin
      cyc();
      checks++;
      if (dut_v !== expv()) begin errors++; $display("FAIL slow cyc=%0d got=%h exp=%h", cyc_n, dut_v, expv()); end
      if (sweep_done) dc.push_back(i);
      if (parked && mode_active == 2'b01) dw++;
    end
    checks++;
    if (dc.size() != 3 || dc[0] != 57 || dc[1] != 121 || dc[2] != 185 || dw != 17) begin
      errors++; $display("FAIL slow_period pulses=%0d first=%0d dwell=%0d exp 3/57/17", dc.size(), (dc.size() > 0) ? dc[0] : -1, dw);
    end
  endtask

  task automatic test_stop_midsweep();
    int n = 0, maxp = 0;
    logic [7:0] c0;
    bit hit = 0;
    go_park();
    c0 = sweep_cnt;
    mode_req = 2'b10;
    for (int i = 0; i < 60 && !hit; i++) begin
      cyc();
      checks++;
      if (dut_v !== expv()) begin errors++; $display("FAIL stop_out cyc=%0d got=%h exp=%h", cyc_n, dut_v, expv()); end
      hit = (arm_pos == 3'd5 && motor_dir);
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL stop_reach5 got=%0d exp=5", arm_pos); end
    mode_req = 2'b00;
    hit = 0;
    while (n < 60 && !hit) begin
      cyc(); n++;
      checks++;
      if (dut_v !== expv()) begin errors++; $display("FAIL stop_back cyc=%0d got=%h exp=%h", cyc_n, dut_v, expv()); end
      if (int'(arm_pos) > maxp) maxp = int'(arm_pos);
      hit = (parked && !sweep_done) || (parked && mode_active == 2'b00);
    end
    checks++;
    if (n != 18 || maxp != 7 || mode_active !== 2'b00 || sweep_cnt !== c0 + 8'd1) begin
      errors++; $display("FAIL stop_park cycles=%0d maxpos=%0d mode=%0d cnt=%0d exp 18/7/0/%0d", n, maxp, mode_active, sweep_cnt, c0 + 8'd1);
    end
  endtask

  task automatic test_dwell_abort();
    bit hit = 0;
    go_park();
    mode_req = 2'b01;
    for (int i = 0; i < 100 && !hit; i++) begin
      cyc();
      checks++;
      if (dut_v !== expv()) begin errors++; $display("FAIL dwell_sweep cyc=%0d got=%h exp=%h", cyc_n, dut_v, expv()); end
      hit = (parked && mode_active == 2'b01);
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL dwell_enter got=%h", dut_v); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (dut_v !== expv()) begin errors++; $display("FAIL dwell_hold cyc=%0d got=%h exp=%h", cyc_n, dut_v, expv()); end
    end
    mode_req = 2'b10;
    cyc();
    checks++;
    if (!(motor_on === 1'b1 && motor_dir === 1'b1 && mode_active === 2'b10 && arm_pos === 3'd0)) begin
      errors++; $display("FAIL dwell_abort got=%h exp on/out/fast", dut_v);
    end
  endtask

  task automatic test_reset_midsweep();
    bit hit = 0;
    mode_req = 2'b10;
    for (int i = 0; i < 100 && !hit; i++) begin
      cyc();
      hit = (arm_pos == 3'd4 && motor_on && !motor_dir);
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rstmid_reach4 got=%h", dut_v); end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++;
    if (dut_v !== 17'b00_000_0_0_1_0_00000000) begin
      errors++; $display("FAIL rstmid got=%h exp=%h", dut_v, 17'b00_000_0_0_1_0_00000000);
    end
  endtask

  task automatic test_wrap();
    int pulses = 0;
    mode_req = 2'b10;
    for (int i = 0; i < 1 + 256 * 28; i++) begin
      cyc();
      checks++;
      if (dut_v !== expv()) begin errors++; $display("FAIL wrap cyc=%0d got=%h exp=%h", cyc_n, dut_v, expv()); end
      if (sweep_done) pulses++;
    end
    checks++;
    if (pulses != 256 || sweep_cnt !== 8'd0) begin
      errors++; $display("FAIL wrap_end pulses=%0d cnt=%0d exp 256/0", pulses, sweep_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) mode_req = 2'($urandom_range(3));
      reset = ($urandom_range(499) == 0);
      cyc();
      checks++;
      if (dut_v !== expv()) begin errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc_n, dut_v, expv()); end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fast();
    test_slow();
    test_stop_midsweep();
    test_dwell_abort();
    test_reset_midsweep();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
